// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl: sequences one external 1-bit full adder over WIDTH bits, LSB first
module somador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_i0,
  output logic             fa_i1,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nx;
  logic [WIDTH:0] s_cat;
  logic c_reg;
  logic [CW-1:0] cnt;
  logic last;
  // concatenating before slicing keeps the shift legal when WIDTH is 1
  assign s_cat = {fa_s, s_sh};
  assign s_nx = s_cat[WIDTH:1];
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign fa_i0 = busy & a_sh[0];
  assign fa_i1 = busy & b_sh[0];
  assign fa_ci = busy & c_reg;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: accept start only when idle, leave RUN after the top bit, DONE lasts one cycle
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && start) ? RUN :
          (state == RUN && last)   ? DONE :
          (state == DONE)          ? IDLE : state;
  end
  // operand load, per-bit shift with carry recirculation, result capture on the final bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_reg <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      c_reg <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      s_sh <= s_nx;
      c_reg <= fa_co;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= s_nx;
        cout <= fa_co;
      end
    end
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// tb_somador_serial_ctrl: scoreboard bench for the bit-serial add controller with a behavioural adder cell
module tb_somador_serial_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, fa_i0, fa_i1, fa_ci, fa_s, fa_co;
  logic [W-1:0] sum;
  int checks = 0, failures = 0;
  int cyc = 0, last_done = -1, n_done = 0;
  logic gap_on = 1'b0;
  logic [W:0] exp_q[$];
  logic [W:0] prev = '0, popped;

  somador_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_i0(fa_i0), .fa_i1(fa_i1), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co)
  );

  assign fa_s = fa_i0 ^ fa_i1 ^ fa_ci;
  assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0h expected=none", {cout, sum});
      end else begin
        popped = exp_q.pop_front();
        chk("result", 32'({cout, sum}), 32'(popped));
      end
      if (gap_on && last_done >= 0) chk("done_gap", cyc - last_done, W + 2);
      last_done = cyc;
    end
  end

  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic c;
    logic [W:0] r;
    int k;
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    exp_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    c = ci;
    for (k = 1; k <= W + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (done) break;
      chk("busy", busy, 1);
      if (k == 1) chk("sum_hold", 32'({cout, sum}), 32'(prev));
      if (k <= W) begin
        chk("fa_i0", fa_i0, x[k-1]);
        chk("fa_i1", fa_i1, y[k-1]);
        chk("fa_ci", fa_ci, c);
        c = (x[k-1] & y[k-1]) | (x[k-1] & c) | (y[k-1] & c);
      end
    end
    chk("latency", k, W + 1);
    chk("busy_in_done", busy, 0);
    prev = r;
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", 32'({cout, sum}), 0);
    chk("rst_fa", {fa_i0, fa_i1, fa_ci}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_add(8'h00, 8'h00, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0);
    do_add(8'hA5, 8'h5A, 1'b1);
    do_add(8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h002);
    n_done = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; end
      if (k == 7) begin a = 8'h01; b = 8'h01; end
      if (k == 20) start = 1'b0;
      if (done) begin
        n_done++;
        chk("held_done_cycle", k, n_done == 1 ? 9 : 19);
      end
    end
    chk("held_done_count", n_done, 2);
    prev = 9'h002;
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", 32'({cout, sum}), 0);
    chk("midrst_fa", {fa_i0, fa_i1, fa_ci}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_idle", {busy, done}, 0);
    prev = '0;
    do_add(8'h10, 8'h20, 1'b0);
    do_add(8'h96, 8'h69, 1'b0);
    gap_on = 1'b1;
    for (int i = 0; i < 1000; i++)
      do_add(W'($urandom), W'($urandom), 1'($urandom));
    gap_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
